// File: rtl/key_press_decoder.sv
// key_press_decoder: synchronise and debounce a push-button, then
// classify gestures into short, long and double-click pulses.
module key_press_decoder #(
  parameter logic [27:0] DEBOUNCE_CYC   = 28'd1_000_000,
  parameter logic [27:0] LONG_CYC       = 28'd50_000_000,
  parameter logic [27:0] GAP_CYC        = 28'd15_000_000,
  parameter logic        KEY_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Key_In,
  output logic        Key_Level,
  output logic        Short_Pulse,
  output logic        Long_Pulse,
  output logic        Double_Pulse,
  output logic [27:0] Press_Len
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PRESS1 = 3'd1;
  localparam logic [2:0] WAIT2  = 3'd2;
  localparam logic [2:0] PRESS2 = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  localparam logic [27:0] DB_M1   = DEBOUNCE_CYC - 28'd1;
  localparam logic [27:0] LONG_M1 = LONG_CYC - 28'd1;
  localparam logic [27:0] GAP_M1  = GAP_CYC - 28'd1;

  // Pin level when the key is not pressed.
  localparam logic REL_LVL = KEY_ACTIVE_LOW;

  logic        sync1;
  logic        sync2;
  logic        sample;
  logic [27:0] db_cnt;
  logic        level_d;
  logic        press_edge;
  logic        release_edge;
  logic [2:0]  state;
  logic [27:0] dur;
  logic [27:0] gap;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= Key_In;
      sync2 <= sync1;
    end
  end

  assign sample = KEY_ACTIVE_LOW ? ~sync2 : sync2;

  // Debounce: level flips only after a full run of differing samples.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      db_cnt    <= '0;
      Key_Level <= 1'b0;
    end else if (sample == Key_Level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_M1) begin
      db_cnt    <= '0;
      Key_Level <= ~Key_Level;
    end else begin
      db_cnt <= db_cnt + 28'd1;
    end
  end

  // Delayed copy of the debounced level for edge strobes.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      level_d <= 1'b0;
    end else begin
      level_d <= Key_Level;
    end
  end

  assign press_edge   = Key_Level & ~level_d;
  assign release_edge = ~Key_Level & level_d;

  // Gesture classifier with registered single-cycle pulses.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= IDLE;
      dur          <= '0;
      gap          <= '0;
      Short_Pulse  <= 1'b0;
      Long_Pulse   <= 1'b0;
      Double_Pulse <= 1'b0;
      Press_Len    <= '0;
    end else begin
      Short_Pulse  <= 1'b0;
      Long_Pulse   <= 1'b0;
      Double_Pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press_edge) begin
            dur   <= '0;
            state <= PRESS1;
          end
        end
        PRESS1, PRESS2: begin
          if (dur != LONG_M1) begin
            dur <= dur + 28'd1;
          end
          if (Key_Level && (dur == LONG_M1)) begin
            Long_Pulse <= 1'b1;
            Press_Len  <= LONG_CYC;
            state      <= HOLD;
          end else if (release_edge) begin
            Press_Len <= dur + 28'd1;
            if (state == PRESS1) begin
              gap   <= '0;
              state <= WAIT2;
            end else begin
              Double_Pulse <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        WAIT2: begin
          if (gap != GAP_M1) begin
            gap <= gap + 28'd1;
          end
          // Timeout beats a coincident press; that press is dropped.
          if (gap == GAP_M1) begin
            Short_Pulse <= 1'b1;
            state       <= IDLE;
          end else if (press_edge) begin
            dur   <= '0;
            state <= PRESS2;
          end
        end
        HOLD: begin
          if (release_edge) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_decoder.sv
// tb_key_press_decoder: random and directed key gestures scored
// against a timestamp-based gesture model.
module tb_key_press_decoder;

  localparam int D = 4;
  localparam int L = 40;
  localparam int G = 20;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Key_In = 1'b1;
  logic        Key_Level;
  logic        Short_Pulse;
  logic        Long_Pulse;
  logic        Double_Pulse;
  logic [27:0] Press_Len;

  key_press_decoder #(
    .DEBOUNCE_CYC  (28'd4),
    .LONG_CYC      (28'd40),
    .GAP_CYC       (28'd20),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .Key_In      (Key_In),
    .Key_Level   (Key_Level),
    .Short_Pulse (Short_Pulse),
    .Long_Pulse  (Long_Pulse),
    .Double_Pulse(Double_Pulse),
    .Press_Len   (Press_Len)
  );

  always #5 CLK = ~CLK;

  // kind: 0 short, 1 long, 2 double
  typedef struct {
    int t;
    int kind;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  n_short = 0;
  int  n_long = 0;
  int  n_dbl = 0;
  int  last_len = 0;

  function automatic void chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               n, a, e, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  bit p1 = 1'b1;
  bit p2 = 1'b1;
  bit hist[$];
  bit m_kl = 1'b0;
  int ph = 0;
  int m_e = 0;
  int m_r = 0;
  int m_l1 = 0;

  function automatic void push_ev(int t, int k, int len);
    ev_t e;
    e.t = t;
    e.kind = k;
    e.len = len;
    exp_q.push_back(e);
  endfunction

  always @(posedge CLK) begin
    bit smp, prev, ad, rise, fall;
    cyc = cyc + 1;
    if (!RSTn) begin
      p1 = 1'b1;
      p2 = 1'b1;
      hist.delete();
      m_kl = 1'b0;
      ph = 0;
      exp_q.delete();
    end else begin
      // pressed = pin low, seen two edges late
      smp = ~p2;
      p2 = p1;
      p1 = Key_In;
      hist.push_back(smp);
      if (hist.size() > D) void'(hist.pop_front());
      ad = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == m_kl) ad = 1'b0;
      prev = m_kl;
      if (ad) begin
        m_kl = ~m_kl;
        hist.delete();
      end
      rise = m_kl && !prev;
      fall = !m_kl && prev;
      case (ph)
        0: if (rise) begin
          ph = 1;
          m_e = cyc;
        end
        1, 3: begin
          if (fall) begin
            if (ph == 1) begin
              m_l1 = cyc - m_e;
              m_r = cyc;
              ph = 2;
            end else begin
              push_ev(cyc + 1, 2, cyc - m_e);
              ph = 0;
            end
          end else if (cyc - m_e == L) begin
            push_ev(cyc + 1, 1, L);
            ph = 4;
          end
        end
        2: begin
          if (rise && (cyc - m_r < G)) begin
            ph = 3;
            m_e = cyc;
          end else if (cyc - m_r == G) begin
            push_ev(cyc + 1, 0, m_l1);
            ph = 0;
          end
        end
        4: if (fall) ph = 0;
        default: ph = 0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    int np, k;
    ev_t h;
    if (RSTn) begin
      chk("key_level", int'(Key_Level), int'(m_kl));
      np = int'(Short_Pulse) + int'(Long_Pulse) + int'(Double_Pulse);
      while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
        h = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: got none expected kind %0d at %0d",
                 h.kind, h.t);
      end
      if (np != 0) begin
        chk("one_pulse", np, 1);
        k = Short_Pulse ? 0 : (Long_Pulse ? 1 : 2);
        n_short += int'(Short_Pulse);
        n_long  += int'(Long_Pulse);
        n_dbl   += int'(Double_Pulse);
        last_len = int'(Press_Len);
        if (exp_q.size() == 0 || exp_q[0].t != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d expected none",
                   k);
        end else begin
          h = exp_q.pop_front();
          chk("pulse_kind", k, h.kind);
          chk("press_len", int'(Press_Len), h.len);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pin(bit v, int n);
    Key_In = v;
    wait_cyc(n);
  endtask

  task automatic outs_zero(string n);
    chk({n, "_lvl"}, int'(Key_Level), 0);
    chk({n, "_short"}, int'(Short_Pulse), 0);
    chk({n, "_long"}, int'(Long_Pulse), 0);
    chk({n, "_dbl"}, int'(Double_Pulse), 0);
    chk({n, "_len"}, int'(Press_Len), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, l0, d0;
    Key_In = 1'b1;
    RSTn = 1'b0;
    wait_cyc(3);
    #1 outs_zero("reset");
    #1 RSTn = 1'b1;
    wait_cyc(10);

    // glitch, then a real 10-cycle press
    pin(1'b0, 3);
    pin(1'b1, 20);
    chk("glitch_lvl", int'(Key_Level), 0);
    Key_In = 1'b0;
    wait_cyc(5);
    chk("lvl_at_5", int'(Key_Level), 0);
    wait_cyc(1);
    chk("lvl_at_6", int'(Key_Level), 1);
    wait_cyc(4);
    pin(1'b1, 40);

    // short click
    s0 = n_short;
    pin(1'b0, 15);
    pin(1'b1, 40);
    chk("short_cnt", n_short - s0, 1);
    chk("short_len", last_len, 15);

    // long press
    l0 = n_long; s0 = n_short; d0 = n_dbl;
    pin(1'b0, 100);
    pin(1'b1, 40);
    chk("long_cnt", n_long - l0, 1);
    chk("long_len", last_len, 40);
    chk("long_noshort", n_short - s0, 0);

    // double click
    s0 = n_short; d0 = n_dbl;
    pin(1'b0, 10); pin(1'b1, 8); pin(1'b0, 10); pin(1'b1, 40);
    chk("dbl_cnt", n_dbl - d0, 1);
    chk("dbl_len", last_len, 10);
    chk("dbl_noshort", n_short - s0, 0);

    // second press long
    s0 = n_short; l0 = n_long; d0 = n_dbl;
    pin(1'b0, 10); pin(1'b1, 8); pin(1'b0, 60); pin(1'b1, 40);
    chk("p2long_cnt", n_long - l0, 1);
    chk("p2long_nodbl", n_dbl - d0, 0);
    chk("p2long_noshort", n_short - s0, 0);

    // press length boundaries
    pin(1'b0, 40); pin(1'b1, 40);
    chk("len40_short", last_len, 40);
    l0 = n_long;
    pin(1'b0, 41); pin(1'b1, 40);
    chk("len41_long", n_long - l0, 1);

    // gap boundaries
    d0 = n_dbl;
    pin(1'b0, 10); pin(1'b1, 19); pin(1'b0, 10); pin(1'b1, 40);
    chk("gap19_dbl", n_dbl - d0, 1);
    s0 = n_short; d0 = n_dbl;
    pin(1'b0, 10); pin(1'b1, 20); pin(1'b0, 10); pin(1'b1, 40);
    chk("gap20_short", n_short - s0, 1);
    chk("gap20_nodbl", n_dbl - d0, 0);
    s0 = n_short;
    pin(1'b0, 10); pin(1'b1, 21); pin(1'b0, 10); pin(1'b1, 40);
    chk("gap21_short", n_short - s0, 2);

    // reset in the middle of a first press
    s0 = n_short + n_long + n_dbl;
    Key_In = 1'b0;
    wait_cyc(D + 3 + 20);
    #2 RSTn = 1'b0;
    exp_q.delete();
    #1 outs_zero("midrst");
    wait_cyc(3);
    Key_In = 1'b1;
    wait_cyc(5);
    #2 RSTn = 1'b1;
    wait_cyc(80);
    chk("midrst_nopulse", n_short + n_long + n_dbl - s0, 0);
    chk("midrst_lvl", int'(Key_Level), 0);

    // random gestures including glitches
    for (int i = 0; i < 150; i++) begin
      pin(1'b0, $urandom_range(55, 1));
      pin(1'b1, $urandom_range(30, 1));
    end
    pin(1'b1, 100);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_press_decoder.md
Name: key_press_decoder

Overview:
- Input-side counterpart to the LED pattern drivers. It takes a raw push-button on the 50 MHz board clock and produces clean user events.
- Processing chain: synchronise, debounce, then classify each gesture as short press, long press or double click.
- Each event is a one-cycle pulse. The LED/pattern blocks consume these pulses to change blink modes.

Parameters:
- DEBOUNCE_CYC, 28'd1_000_000, cycles the synchronised input must be stable before the debounced level changes (20 ms).
- LONG_CYC, 28'd50_000_000, press duration in cycles that qualifies as a long press (1 s).
- GAP_CYC, 28'd15_000_000, maximum released gap in cycles between clicks of a double click (300 ms).
- KEY_ACTIVE_LOW, 1'b1, 1 = key pulls low when pressed; 0 = key drives high when pressed.

Ports:
- CLK  input  1  system clock, 50 MHz.
- RSTn  input  1  asynchronous active-low reset.
- Key_In  input  1  raw asynchronous key pin.
- Key_Level  output  1  debounced level, 1 = pressed.
- Short_Pulse  output  1  one-cycle pulse for a single short click.
- Long_Pulse  output  1  one-cycle pulse when a press reaches LONG_CYC.
- Double_Pulse  output  1  one-cycle pulse for a completed double click.
- Press_Len  output  28  duration in cycles of the last completed or long-qualified press, saturating at LONG_CYC.

Behaviour:
- Reset: asynchronous, active-low on RSTn; clock CLK. All outputs reset to 0, FSM to IDLE, all counters to 0, synchroniser flops to the released level.
- Input conditioning:
  - Key_In passes through a 2-flop synchroniser, then is normalised so that pressed = 1, using KEY_ACTIVE_LOW.
- Debounce:
  - A 28-bit counter clears on every cycle where the normalised sample equals Key_Level.
  - While the sample differs from Key_Level, the counter increments.
  - When the counter equals DEBOUNCE_CYC-1 and the sample still differs, Key_Level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYC cycles never changes Key_Level.
  - Latency from the pin edge to the Key_Level change is DEBOUNCE_CYC+2 cycles.
- Edges: press_edge and release_edge are one-cycle strobes, registered from Key_Level.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, HOLD. Duration counter dur and gap counter gap are both 28 bits.
- IDLE:
  - On press_edge: clear dur, go to PRESS1.
- PRESS1 (dur increments each cycle):
  - If dur == LONG_CYC-1 while still pressed: Long_Pulse=1 next cycle, Press_Len=LONG_CYC, go to HOLD.
  - Else on release_edge: Press_Len=dur+1, clear gap, go to WAIT2.
- WAIT2 (gap increments each cycle):
  - If press_edge arrives while gap < GAP_CYC-1: clear dur, go to PRESS2.
  - If gap == GAP_CYC-1: Short_Pulse=1, go to IDLE.
  - If press_edge and gap == GAP_CYC-1 occur on the same cycle, the timeout wins: Short_Pulse fires and the FSM goes to IDLE. The press_edge is then consumed; it does not start a new gesture.
- PRESS2 (dur increments each cycle):
  - On release_edge before LONG_CYC: Double_Pulse=1, Press_Len=dur+1, go to IDLE.
  - If dur == LONG_CYC-1: Long_Pulse=1, Press_Len=LONG_CYC, go to HOLD. The first click is discarded and no Short_Pulse is issued.
- HOLD:
  - On release_edge: go to IDLE with no pulse. Holding longer never re-fires Long_Pulse.
- Output rules:
  - Pulses are registered and exactly one cycle wide.
  - At most one pulse is asserted per cycle.
  - Exactly one pulse is issued per gesture, or none for a gesture that ends in HOLD.
- Counter widths: counters never wrap. dur stops at LONG_CYC-1 and gap stops at GAP_CYC-1.
- Parameter range: 2 ≤ each parameter ≤ 2^28-1.
- Reset mid-gesture: immediate return to IDLE with all outputs at 0. A key still held when reset releases is seen as a new press once Key_Level debounces to 1.

Test Plan:
- Sim parameters: DEBOUNCE_CYC=4, LONG_CYC=40, GAP_CYC=20, KEY_ACTIVE_LOW=1.
- Glitch reject: Key_In low for 3 cycles, then high → Key_Level stays 0, no pulses. Low for 10 cycles → Key_Level=1 six cycles after the falling edge.
- Short click: press held 15 cycles after debounce, then release and wait 30 cycles → exactly one Short_Pulse, 20 cycles after the debounced release; Press_Len=15.
- Long press: hold 100 cycles → Long_Pulse once, 40 cycles after the debounced press; Press_Len=40; no pulse on release.
- Double click: press 10, gap 8, press 10 → one Double_Pulse on the second debounced release; Press_Len=10; no Short_Pulse.
- Second press long: press 10, gap 8, hold 60 → single Long_Pulse; no Short_Pulse or Double_Pulse.
- Reset mid-PRESS1: assert RSTn=0 at dur=20 → all outputs 0 immediately. Release key and RSTn → no stale pulse, FSM in IDLE.
